// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame size, sample width, bit-reversal helper and
// the complex-sample types. Optional macro FFT_REORDER_POWER_EN adds a
// per-entry power field to the reorder storage entry.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_W     = 16;
    localparam int FFT_LOG2N = $clog2(FFT_N);

    typedef logic [FFT_LOG2N-1:0] idx_t;

    typedef struct packed {
        logic signed [FFT_W-1:0] r;
        logic signed [FFT_W-1:0] i;
    } cplx_t;

`ifdef FFT_REORDER_POWER_EN
    localparam int FFT_PW = 2*FFT_W + 1;

    typedef struct packed {
        cplx_t             s;
        logic [FFT_PW-1:0] pwr;
    } entry_t;

    // r^2 + i^2; both squares are non-negative so they are zero-extended
    // before the add to keep the carry.
    function automatic logic [FFT_PW-1:0] cplx_power(input cplx_t s);
        logic signed [2*FFT_W-1:0] rr;
        logic signed [2*FFT_W-1:0] ii;
        rr = (2*FFT_W)'(s.r) * (2*FFT_W)'(s.r);
        ii = (2*FFT_W)'(s.i) * (2*FFT_W)'(s.i);
        return {1'b0, rr} + {1'b0, ii};
    endfunction
`else
    typedef struct packed {
        cplx_t s;
    } entry_t;
`endif

    // Reverse the LOG2N index bits (N=8: 1<->4, 3<->6).
    function automatic idx_t bitrev(input idx_t a);
        idx_t res;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            res[b] = a[FFT_LOG2N-1-b];
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_8p_reorder_if.sv
// Stream bundle for fft_8p_reorder. Optional macro FFT_REORDER_POWER_EN adds
// the out_pwr signal.
//
// Handshake: a sample moves on a side only in a cycle where its valid and
// ready are both high at the rising clock edge. Input side: in_valid with
// in_ready low drops the sample and raises the sticky overflow flag.
// Output side: while out_valid is high and out_ready low, all out_* signals
// hold stable.
interface fft_8p_reorder_if import fft_pkg::*; ();

    logic                    in_valid;
    logic signed [FFT_W-1:0] in_r;
    logic signed [FFT_W-1:0] in_i;
    logic                    in_ready;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [FFT_W-1:0] out_r;
    logic signed [FFT_W-1:0] out_i;
    idx_t                    out_idx;
    logic                    out_last;
    logic                    overflow;
`ifdef FFT_REORDER_POWER_EN
    logic [FFT_PW-1:0]       out_pwr;

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last, overflow, out_pwr
    );
    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last, overflow, out_pwr
    );
`else
    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last, overflow
    );
    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last, overflow
    );
`endif

endinterface

// File: rtl/fft_reorder_bank.sv
// N-entry register file: one synchronous write port, one combinational read
// port. Entries reset to zero so the read port shows zero after reset.
module fft_reorder_bank import fft_pkg::*; (
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  idx_t   waddr,
    input  entry_t wdata,
    input  idx_t   raddr,
    output entry_t rdata
);

    entry_t mem_q [FFT_N];
    entry_t mem_d [FFT_N];

    // Next storage contents: only the addressed entry changes on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FFT_N; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_8p_reorder.sv
// Output reorder stage after fft_8p: accepts bins in bit-reversed order,
// stores them in a two-bank ping-pong buffer and streams them out in natural
// order. Optional macro FFT_REORDER_POWER_EN adds out_pwr (r^2 + i^2),
// computed at write time and stored alongside each sample.
module fft_8p_reorder import fft_pkg::*; (
    input logic              clk,
    input logic              rst,
    fft_8p_reorder_if.slave  bus
);

    localparam idx_t LAST = idx_t'(FFT_N - 1);

    logic [1:0] full_q, full_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    idx_t       wc_q, wc_d;
    idx_t       rc_q, rc_d;
    logic       overflow_q, overflow_d;

    logic       in_ready;
    logic       wr_fire;
    logic       rd_fire;
    logic [1:0] bank_we;
    entry_t     wr_entry;
    entry_t     rd_entry [2];

    // Readiness comes only from registered state, so a bank freed by the
    // final read becomes writable one cycle later.
    assign in_ready = !full_q[wb_q];
    assign wr_fire  = bus.in_valid && in_ready;
    assign rd_fire  = full_q[rb_q] && bus.out_ready;

    // Build the entry written this cycle (sample plus optional power).
    always_comb begin
        wr_entry     = '0;
        wr_entry.s.r = bus.in_r;
        wr_entry.s.i = bus.in_i;
`ifdef FFT_REORDER_POWER_EN
        wr_entry.pwr = cplx_power(wr_entry.s);
`endif
    end

    // Ping-pong pointer and full-flag updates. Write and read always target
    // different banks (one is empty, the other full), so both may complete
    // a frame in the same cycle without conflict.
    always_comb begin
        full_d     = full_q;
        wb_d       = wb_q;
        wc_d       = wc_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        overflow_d = overflow_q | (bus.in_valid & ~in_ready);
        if (wr_fire) begin
            if (wc_q == LAST) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                wc_d         = '0;
            end else begin
                wc_d = wc_q + idx_t'(1);
            end
        end
        if (rd_fire) begin
            if (rc_q == LAST) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
                rc_d         = '0;
            end else begin
                rc_d = rc_q + idx_t'(1);
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wc_q       <= '0;
            rc_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
            wc_q       <= wc_d;
            rc_q       <= rc_d;
            overflow_q <= overflow_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        assign bank_we[g] = wr_fire && (wb_q == 1'(g));

        fft_reorder_bank u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[g]),
            .waddr (bitrev(wc_q)),
            .wdata (wr_entry),
            .raddr (rc_q),
            .rdata (rd_entry[g])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = full_q[rb_q];
    assign bus.out_r     = rd_entry[rb_q].s.r;
    assign bus.out_i     = rd_entry[rb_q].s.i;
    assign bus.out_idx   = rc_q;
    assign bus.out_last  = (rc_q == LAST);
    assign bus.overflow  = overflow_q;
`ifdef FFT_REORDER_POWER_EN
    assign bus.out_pwr   = rd_entry[rb_q].pwr;
`endif

endmodule

// File: tb/tb_fft_8p_reorder.sv
// Bench for fft_8p_reorder: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a frame-level model.
// Build with FFT_REORDER_POWER_EN defined to also cover out_pwr.
module tb_fft_8p_reorder;
    import fft_pkg::*;

    localparam int N = FFT_N;
    localparam int W = FFT_W;

    logic clk;
    logic rst;

    fft_8p_reorder_if bus ();

    fft_8p_reorder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and check ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Completed frames waiting to drain, in natural order, flattened.
    logic [W-1:0] exp_r_q[$];
    logic [W-1:0] exp_i_q[$];
    logic [W-1:0] part_r [N];
    logic [W-1:0] part_i [N];
`ifdef FFT_REORDER_POWER_EN
    logic [2*W:0] exp_p_q[$];
    logic [2*W:0] got_p[$];
`endif
    int   m_wc  = 0;
    int   m_rc  = 0;
    logic m_ovf = 1'b0;

    // Observed output transfers, for the directed literal checks.
    logic [W-1:0] got_r[$];
    logic [W-1:0] got_i[$];
    int           got_idx[$];
    logic         got_last[$];

    // Bin number of the p-th arriving sample: reverse the LOG2N bits of p.
    function automatic int brev(input int p);
        int x = p;
        int r = 0;
        for (int b = 0; b < FFT_LOG2N; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        int   nfull;
        int   bin;
        logic can_in;
        if (rst) begin
            exp_r_q.delete();
            exp_i_q.delete();
`ifdef FFT_REORDER_POWER_EN
            exp_p_q.delete();
`endif
            m_wc  = 0;
            m_rc  = 0;
            m_ovf = 1'b0;
        end
        nfull  = (exp_r_q.size() + m_rc) / N;
        can_in = (nfull < 2);
        chk("in_ready", bus.in_ready, can_in);
        chk("overflow", bus.overflow, m_ovf);
        chk("out_valid", bus.out_valid, nfull > 0);
        if (nfull > 0) begin
            chk("out_r", $unsigned(bus.out_r), exp_r_q[0]);
            chk("out_i", $unsigned(bus.out_i), exp_i_q[0]);
            chk("out_idx", bus.out_idx, m_rc);
            chk("out_last", bus.out_last, m_rc == N-1);
`ifdef FFT_REORDER_POWER_EN
            chk("out_pwr", bus.out_pwr, exp_p_q[0]);
`endif
        end
        if (!rst) begin
            if (bus.in_valid && !can_in) m_ovf = 1'b1;
            if (nfull > 0 && bus.out_ready) begin
                got_r.push_back(bus.out_r);
                got_i.push_back(bus.out_i);
                got_idx.push_back(int'(bus.out_idx));
                got_last.push_back(bus.out_last);
                void'(exp_r_q.pop_front());
                void'(exp_i_q.pop_front());
`ifdef FFT_REORDER_POWER_EN
                got_p.push_back(bus.out_pwr);
                void'(exp_p_q.pop_front());
`endif
                m_rc = (m_rc + 1) % N;
            end
            if (bus.in_valid && can_in) begin
                bin = brev(m_wc);
                part_r[bin] = bus.in_r;
                part_i[bin] = bus.in_i;
                m_wc++;
                if (m_wc == N) begin
                    for (int b = 0; b < N; b++) begin
                        exp_r_q.push_back(part_r[b]);
                        exp_i_q.push_back(part_i[b]);
`ifdef FFT_REORDER_POWER_EN
                        exp_p_q.push_back((2*W+1)'(longint'($signed(part_r[b])) * longint'($signed(part_r[b]))
                                        + longint'($signed(part_i[b])) * longint'($signed(part_i[b]))));
`endif
                    end
                    m_wc = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] r, input logic [W-1:0] i);
        bus.in_valid = v;
        bus.in_r     = r;
        bus.in_i     = i;
        tick();
    endtask

    task automatic clear_got();
        got_r.delete();
        got_i.delete();
        got_idx.delete();
        got_last.delete();
`ifdef FFT_REORDER_POWER_EN
        got_p.delete();
`endif
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_r"}, $unsigned(bus.out_r), 0);
        chk({tag, "_out_i"}, $unsigned(bus.out_i), 0);
        chk({tag, "_out_idx"}, bus.out_idx, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        chk({tag, "_overflow"}, bus.overflow, 0);
`ifdef FFT_REORDER_POWER_EN
        chk({tag, "_out_pwr"}, bus.out_pwr, 0);
`endif
    endtask

    task automatic do_reset(input string tag);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_reset_values(tag);
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Feed k = 0..7 as (100k, -k) and check the natural-order result.
    int ord_lit [N] = '{0, 400, 200, 600, 100, 500, 300, 700};

    task automatic ordering_frame(input string tag);
        clear_got();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            drive(1'b1, W'(100 * k), W'(-k));
            if (k == N-2) chk({tag, "_valid_before"}, bus.out_valid, 0);
            if (k == N-1) chk({tag, "_valid_latency"}, bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        repeat (12) tick();
        chk({tag, "_count"}, got_r.size(), N);
        if (got_r.size() == N) begin
            for (int j = 0; j < N; j++) begin
                chk({tag, "_r"}, got_r[j], ord_lit[j]);
                chk({tag, "_idx"}, got_idx[j], j);
                chk({tag, "_last"}, got_last[j], j == N-1);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lows;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_i      = '0;
        bus.out_ready = 1'b0;
        #1;
        do_reset("reset0");

        // Ordering and latency.
        ordering_frame("order");

        // Back-pressure: two frames fill both banks, the 17th is dropped.
        do_reset("reset1");
        clear_got();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2*N; k++) drive(1'b1, W'(10 + k), W'(k));
        chk("bp_in_ready_low", bus.in_ready, 0);
        drive(1'b1, W'(999), W'(999));
        chk("bp_overflow", bus.overflow, 1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("bp_count", got_r.size(), 2*N);
        if (got_r.size() == 2*N) begin
            chk("bp_first_bin0", got_r[0], 10);
            chk("bp_first_bin1", got_r[1], 14);
            chk("bp_second_bin3", got_r[N+3], 10 + N + 6);
        end
        chk("bp_overflow_sticky", bus.overflow, 1);

        // Streaming: 32 back-to-back samples with out_ready high.
        do_reset("reset2");
        clear_got();
        bus.out_ready = 1'b1;
        lows = 0;
        for (int k = 0; k < 4*N; k++) begin
            if (!bus.in_ready) lows++;
            drive(1'b1, W'($urandom), W'($urandom));
        end
        bus.in_valid = 1'b0;
        repeat (12) tick();
        chk("stream_in_ready_lows", lows, 0);
        chk("stream_overflow", bus.overflow, 0);
        chk("stream_count", got_r.size(), 4*N);

        // Reset in the middle of a frame, then a clean frame.
        for (int k = 0; k < 5; k++) drive(1'b1, W'(7 + k), W'(3));
        do_reset("reset_mid");
        ordering_frame("order_after_rst");

`ifdef FFT_REORDER_POWER_EN
        // (3,4) arriving at k = 1 lands on bin 4 with power 25.
        do_reset("reset_pwr");
        clear_got();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (k == 1) drive(1'b1, W'(3), W'(4));
            else        drive(1'b1, W'(0), W'(0));
        end
        bus.in_valid = 1'b0;
        repeat (12) tick();
        chk("pwr_count", got_p.size(), N);
        if (got_p.size() == N) begin
            chk("pwr_idx4", got_idx[4], 4);
            chk("pwr_bin4", got_p[4], 25);
            chk("pwr_bin1", got_p[1], 0);
        end
`endif

        // Randomized traffic with random back-pressure.
        do_reset("reset3");
        for (int c = 0; c < 2500; c++) begin
            bus.out_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 9) < 8, W'($urandom), W'($urandom));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) tick();
        chk("random_drained", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
